// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {REQ, IDLE, DRAIN, HALT} fetch_state_t;

    localparam logic [15:0] PC_STEP           = 16'd2;
    localparam logic [15:0] HALT_WORD_DEFAULT = 16'hFFFF;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } entry_t;

    function automatic logic [15:0] align_pc(input logic [15:0] pc);
        return {pc[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: instruction memory handshake, decode handshake and redirect.
interface instr_fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc, halted,
        input  mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc, halted,
        output mem_ack, mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {instr, pc} entries; synchronous flush, async reset.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    entry_t          slots [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign do_push = push && (count != FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign head    = slots[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) slots[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: sequential PC generation, single-outstanding memory requests,
// prefetch queue to decode, halt detection and redirect/flush.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_t  state, state_next;
    logic [15:0]   fetch_pc, fetch_pc_next;
    logic [15:0]   drain_addr, drain_addr_next;
    logic          outstanding;
    logic          mem_fire;
    logic          deq;
    logic          enq;
    entry_t        push_entry;
    entry_t        head;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic [CW-1:0] count_after_ack;

    // Reset gates the request combinationally so it drops the moment reset rises.
    assign outstanding  = (state == REQ) || (state == DRAIN);
    assign bus.mem_req  = outstanding && !reset;
    assign bus.mem_addr = (state == DRAIN) ? drain_addr : fetch_pc;
    assign mem_fire     = bus.mem_req && bus.mem_ack;

    assign bus.instr_valid = !q_empty;
    assign bus.instr       = head.instr;
    assign bus.instr_pc    = head.pc;
    assign bus.halted      = (state == HALT) && q_empty;
    assign deq             = bus.instr_valid && bus.instr_ready;

    assign push_entry      = {bus.mem_rdata, fetch_pc};
    assign count_after_ack = q_count + CW'(1) - CW'(deq);

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (bus.redirect),
        .push      (enq),
        .push_data (push_entry),
        .pop       (deq),
        .head      (head),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= REQ;
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            drain_addr <= drain_addr_next;
        end
    end

    always_comb begin
        state_next      = state;
        fetch_pc_next   = fetch_pc;
        drain_addr_next = drain_addr;
        enq             = 1'b0;
        if (bus.redirect) begin
            fetch_pc_next = align_pc(bus.redirect_pc);
            case (state)
                REQ: begin
                    if (!mem_fire) begin
                        state_next      = DRAIN;
                        drain_addr_next = fetch_pc;
                    end
                end
                // An ack landing with the redirect completes the old request, so no drain is needed.
                DRAIN:   state_next = mem_fire ? REQ : DRAIN;
                IDLE:    state_next = REQ;
                HALT:    state_next = REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (mem_fire) begin
                        enq           = 1'b1;
                        fetch_pc_next = fetch_pc + PC_STEP;
                        if (bus.mem_rdata == HALT_WORD)  state_next = HALT;
                        else if (count_after_ack < DEPTH_C) state_next = REQ;
                        else                             state_next = IDLE;
                    end
                end
                IDLE:  if (q_count < DEPTH_C) state_next = REQ;
                DRAIN: if (mem_fire) state_next = REQ;
                HALT:  state_next = HALT;
            endcase
        end
    end
endmodule
